instr_fetch_unit: RTL and testbench

//  Instruction fetch/issue front end for the single-cycle accumulator CPU; producer side of the control unit's IR input.

---
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue front end: owns PC, fetches over imem req/ack, presents IR to the CU.
// Latency: ir_valid rises the cycle after imem_ack; next imem_req rises the cycle after the IR handshake.
// Backpressure: IR is held stable while ir_ready=0; no new fetch is issued until the IR retires.
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [5:0]         ir_op,
  output logic [ADDR_W-1:0]  ir_addr,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [5:0] OP_STP = 6'b000101;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                imem_req_q, imem_req_d;
  logic [5:0]          ir_op_q, ir_op_d;
  logic [ADDR_W-1:0]   ir_addr_q, ir_addr_d;
  logic                ir_valid_q, ir_valid_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;

  // Instruction bits between the operand and opcode fields are not used here.
  logic unused_rdata;
  assign unused_rdata = ^imem_rdata;

  // Next-state and next-output computation for the fetch/issue sequencer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = imem_req_q;
    ir_op_d      = ir_op_q;
    ir_addr_d    = ir_addr_q;
    ir_valid_d   = ir_valid_q;
    halted_d     = halted_q;
    retire_cnt_d = retire_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          imem_req_d = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        if (imem_ack) begin
          ir_op_d    = imem_rdata[INSTR_W-1 -: 6];
          ir_addr_d  = imem_rdata[ADDR_W-1:0];
          ir_valid_d = 1'b1;
          imem_req_d = 1'b0;
          pc_d       = pc_q + ADDR_W'(1);
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          if (!(&retire_cnt_q)) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
          end
          if (ir_op_q == OP_STP) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            // PC already points past this instruction; a taken branch overrides it.
            if (br_taken) begin
              pc_d = br_target;
            end
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end

      S_HALT: begin
        if (start) begin
          pc_d       = '0;
          halted_d   = 1'b0;
          imem_req_d = 1'b1;
          state_d    = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      imem_req_q   <= 1'b0;
      ir_op_q      <= '0;
      ir_addr_q    <= '0;
      ir_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      ir_op_q      <= ir_op_d;
      ir_addr_q    <= ir_addr_d;
      ir_valid_q   <= ir_valid_d;
      halted_q     <= halted_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign ir_op      = ir_op_q;
  assign ir_addr    = ir_addr_q;
  assign ir_valid   = ir_valid_q;
  assign halted     = halted_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized program run.
// The bench plays both instruction memory and CU, tracking expected PC/count/halt per transaction.
// A second instance with a 2-bit retire counter shares the stimulus to exercise saturation.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack, ir_ready, br_taken;
  logic [15:0] imem_rdata;
  logic [7:0]  br_target;

  logic        imem_req, ir_valid, halted;
  logic [7:0]  imem_addr, ir_addr;
  logic [5:0]  ir_op;
  logic [15:0] retire_cnt;

  logic        imem_req2, ir_valid2, halted2;
  logic [7:0]  imem_addr2, ir_addr2;
  logic [5:0]  ir_op2;
  logic [1:0]  retire_cnt2;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state
  int          exp_pc;
  int          exp_cnt;
  bit          exp_halted;
  logic [5:0]  exp_op;
  logic [7:0]  exp_ia;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_op(ir_op), .ir_addr(ir_addr), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_target(br_target), .halted(halted), .retire_cnt(retire_cnt)
  );

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_op(ir_op2), .ir_addr(ir_addr2), .ir_valid(ir_valid2), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_target(br_target), .halted(halted2), .retire_cnt(retire_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  // Memory side: request is expected to be up now; answer after 'delay' idle cycles.
  task automatic do_fetch(input int delay, input logic [15:0] word);
    for (int i = 0; i < delay; i++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, exp_pc);
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    chk("fetch_req_ack", imem_req, 1);
    chk("fetch_addr_ack", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    exp_op = word[15:10];
    exp_ia = word[7:0];
    exp_pc = (exp_pc + 1) % 256;
    chk("ir_valid_up", ir_valid, 1);
    chk("ir_op", ir_op, exp_op);
    chk("ir_addr", ir_addr, exp_ia);
    chk("req_dropped", imem_req, 0);
  endtask

  // CU side: stall for 'stall' cycles (with stray branch/ack/start noise), then retire.
  task automatic do_issue(input int stall, input bit br, input logic [7:0] tgt);
    for (int i = 0; i < stall; i++) begin
      ir_ready   = 1'b0;
      br_taken   = 1'($urandom_range(0, 1));
      br_target  = 8'($urandom);
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      start      = 1'($urandom_range(0, 1));
      tick();
      chk("stall_valid", ir_valid, 1);
      chk("stall_op", ir_op, exp_op);
      chk("stall_addr", ir_addr, exp_ia);
      chk("stall_noreq", imem_req, 0);
    end
    imem_ack  = 1'b0;
    start     = 1'b0;
    ir_ready  = 1'b1;
    br_taken  = br;
    br_target = tgt;
    tick();
    ir_ready  = 1'b0;
    br_taken  = 1'b0;
    exp_cnt++;
    if (exp_op == 6'b000101) exp_halted = 1'b1;
    else if (br)             exp_pc = tgt;
    chk("retire_valid", ir_valid, 0);
    chk("retire_halted", halted, exp_halted);
    chk("retire_cnt", retire_cnt, sat(exp_cnt, 65535));
    chk("retire_cnt2", retire_cnt2, sat(exp_cnt, 3));
    chk("retire_req", imem_req, !exp_halted);
    if (!exp_halted) chk("retire_next_addr", imem_addr, exp_pc);
  endtask

  task automatic restart_from_halt(input int idle);
    for (int i = 0; i < idle; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("halt_noreq", imem_req, 0);
      chk("halt_flag", halted, 1);
      chk("halt_novalid", ir_valid, 0);
    end
    imem_ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc = 0;
    exp_halted = 1'b0;
    chk("restart_halted", halted, 0);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0;
    br_taken = 1'b0; br_target = '0; imem_rdata = '0;
    exp_pc = 0; exp_cnt = 0; exp_halted = 1'b0; exp_op = '0; exp_ia = '0;
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_op", ir_op, 0);
    chk("rst_addr", ir_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_pc", imem_addr, 0);
    rst = 1'b0;

    // Reset in the middle of a fetch; the late ack must be ignored.
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_req", imem_req, 1);
    tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("t1_req_cleared", imem_req, 0);
    chk("t1_valid", ir_valid, 0);
    chk("t1_halted", halted, 0);
    chk("t1_cnt", retire_cnt, 0);
    imem_ack = 1'b1; imem_rdata = 16'h1805; tick(); imem_ack = 1'b0;
    chk("t1_late_ack_valid", ir_valid, 0);
    chk("t1_late_ack_req", imem_req, 0);

    // Basic fetch with 3-cycle ack latency.
    start = 1'b1; tick(); start = 1'b0;
    do_fetch(3, 16'h1805);
    chk("t2_op", ir_op, 6'b000110);
    do_issue(0, 1'b0, 8'h00);
    chk("t2_addr1", imem_addr, 8'h01);
    chk("t2_cnt1", retire_cnt, 1);

    // Backpressure with noise on branch/ack/start.
    do_fetch(0, 16'h0c33);
    do_issue(5, 1'b0, 8'h00);

    // Jump.
    do_fetch(1, 16'h2440);
    do_issue(0, 1'b1, 8'h40);
    chk("t4_jmp_addr", imem_addr, 8'h40);

    // Halt and restart.
    do_fetch(0, 16'h1400);
    do_issue(2, 1'b1, 8'h77);
    restart_from_halt(10);

    // PC wrap at 0xFF, and 2-bit counter already saturated.
    do_fetch(0, 16'h2400);
    do_issue(0, 1'b1, 8'hFF);
    do_fetch(2, 16'h0811);
    do_issue(1, 1'b0, 8'h00);
    chk("t6_wrap_addr", imem_addr, 8'h00);
    chk("t6_sat_cnt2", retire_cnt2, 2'd3);

    // Randomized program run.
    for (int n = 0; n < 150; n++) begin
      w = 16'($urandom);
      if (w[15:10] == 6'b000101 && $urandom_range(0, 3) != 0) w[10] = 1'b0;
      do_fetch($urandom_range(0, 3), w);
      do_issue($urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom));
      if (exp_halted) restart_from_halt($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
